axis_packet_generator: RTL

- Synthesisable, runtime-configurable AXI4-Stream packet source. It drives the TX streaming-data port of the UDP streaming apps (axis_streaming_data_tx_*) for bring-up and line-rate tests.
- Replaces the fixed free-running stimulus (8 full beats, fixed pattern, ignores tready) with:
  - byte-granular packet length;
  - inter-packet gap;
  - packet count;
  - selectable payload patterns;
  - full tready back-pressure compliance.

---
 rtl/axis_packet_generator_pkg.sv | 24 ++
 rtl/axis_pattern_lfsr32.sv | 36 +++
 rtl/axis_packet_generator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_generator_pkg.sv
// Shared definitions for the AXI4-Stream packet generator.
// Holds the payload pattern selectors, the FSM state type and the LFSR polynomial/seed.
package axis_packet_generator_pkg;

    localparam logic [1:0] C_PAT_BYTE_IDX = 2'd0;
    localparam logic [1:0] C_PAT_BEAT_IDX = 2'd1;
    localparam logic [1:0] C_PAT_SEQ      = 2'd2;
    localparam logic [1:0] C_PAT_LFSR     = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } gen_state_e;

    // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting left: taps at bits 31, 21, 1, 0
    localparam logic [31:0] C_LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] C_LFSR_SEED = 32'hFFFF_FFFF;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & C_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_pattern_lfsr32.sv
// 32-bit pattern LFSR.
// Ports: clk, aresetn (sync, active-low), enable (advance one step), load (take seed,
// wins over enable), seed (value to load), state (current LFSR value).
module axis_pattern_lfsr32
    import axis_packet_generator_pkg::*;
(
    input  logic        clk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (enable) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= C_LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/axis_packet_generator.sv
// Runtime-configurable AXI4-Stream packet source with back-pressure support.
// Ports: axis_clk/axis_aresetn (sync active-low); start/stop control pulses; cfg_* packet
// length (bytes), inter-packet gap (cycles), packet count (0 = endless), pattern mode;
// m_axis_* master stream; busy, cfg_error (rejected start), packets_sent/beats_sent stats.
module axis_packet_generator
    import axis_packet_generator_pkg::*;
#(
    parameter int unsigned G_AXIS_DATA_WIDTH = 1024,
    parameter int unsigned G_LEN_WIDTH       = 16,
    parameter int unsigned G_GAP_WIDTH       = 16,
    parameter int unsigned G_COUNT_WIDTH     = 32
) (
    input  logic                           axis_clk,
    input  logic                           axis_aresetn,
    input  logic                           start,
    input  logic                           stop,
    input  logic [G_LEN_WIDTH-1:0]         cfg_packet_length,
    input  logic [G_GAP_WIDTH-1:0]         cfg_gap_cycles,
    input  logic [G_COUNT_WIDTH-1:0]       cfg_packet_count,
    input  logic [1:0]                     cfg_pattern_mode,
    output logic [G_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [G_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           busy,
    output logic                           cfg_error,
    output logic [G_COUNT_WIDTH-1:0]       packets_sent,
    output logic [G_COUNT_WIDTH-1:0]       beats_sent
);

    localparam int unsigned B     = G_AXIS_DATA_WIDTH / 8;
    localparam int unsigned LOG2B = $clog2(B);

    localparam logic [G_LEN_WIDTH-1:0]   LEN_ONE = {{(G_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [G_GAP_WIDTH-1:0]   GAP_ONE = {{(G_GAP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [G_COUNT_WIDTH-1:0] CNT_ONE = {{(G_COUNT_WIDTH-1){1'b0}}, 1'b1};

    gen_state_e               state_q, state_d;
    logic [G_LEN_WIDTH-1:0]   last_beat_q, last_beat_d;
    logic [LOG2B-1:0]         rem_q, rem_d;
    logic [G_GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [G_COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]               mode_q, mode_d;
    logic [G_LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [G_GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic                     stop_pend_q, stop_pend_d;
    logic [G_COUNT_WIDTH-1:0] pkts_q, pkts_d;
    logic [G_COUNT_WIDTH-1:0] beats_q, beats_d;
    logic                     cfg_err_q, cfg_err_d;

    logic                     lfsr_load;
    logic [31:0]              lfsr_state;
    logic                     hs;
    logic                     is_last;
    logic                     stop_eff;
    logic [G_COUNT_WIDTH-1:0] pkts_inc;
    logic [G_LEN_WIDTH-1:0]   cfg_full_beats;
    logic                     cfg_has_rem;
    logic [31:0]              seq_word;
    logic [7:0]               byte_val;
    logic                     keep_bit;

    assign m_axis_tvalid  = (state_q == StSend);
    assign hs             = m_axis_tvalid & m_axis_tready;
    assign is_last        = (beat_q == last_beat_q);
    // A stop arriving in the same cycle as the boundary decision is honoured immediately
    assign stop_eff       = stop_pend_q | stop;
    assign pkts_inc       = pkts_q + CNT_ONE;
    assign cfg_full_beats = cfg_packet_length >> LOG2B;
    assign cfg_has_rem    = |cfg_packet_length[LOG2B-1:0];

    always_comb begin
        state_d     = state_q;
        last_beat_d = last_beat_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        count_d     = count_q;
        mode_d      = mode_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        pkts_d      = pkts_q;
        beats_d     = beats_q;
        cfg_err_d   = 1'b0;
        lfsr_load   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_packet_length == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        last_beat_d = cfg_has_rem ? cfg_full_beats : cfg_full_beats - LEN_ONE;
                        rem_d       = cfg_packet_length[LOG2B-1:0];
                        gap_d       = cfg_gap_cycles;
                        count_d     = cfg_packet_count;
                        mode_d      = cfg_pattern_mode;
                        beat_d      = '0;
                        pkts_d      = '0;
                        beats_d     = '0;
                        stop_pend_d = 1'b0;
                        lfsr_load   = 1'b1;
                        state_d     = StSend;
                    end
                end
            end
            StSend: begin
                stop_pend_d = stop_eff;
                if (hs) begin
                    beats_d = beats_q + CNT_ONE;
                    if (is_last) begin
                        beat_d = '0;
                        pkts_d = pkts_inc;
                        if (stop_eff || (count_q != '0 && pkts_inc == count_q)) begin
                            state_d     = StIdle;
                            stop_pend_d = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = StGap;
                            gap_cnt_d = gap_q - GAP_ONE;
                        end
                    end else begin
                        beat_d = beat_q + LEN_ONE;
                    end
                end
            end
            StGap: begin
                if (stop_eff) begin
                    state_d     = StIdle;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == '0) begin
                    state_d = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_aresetn) begin
            state_q     <= StIdle;
            last_beat_q <= '0;
            rem_q       <= '0;
            gap_q       <= '0;
            count_q     <= '0;
            mode_q      <= '0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            pkts_q      <= '0;
            beats_q     <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_beat_q <= last_beat_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            pkts_q      <= pkts_d;
            beats_q     <= beats_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    axis_pattern_lfsr32 u_lfsr (
        .clk     (axis_clk),
        .aresetn (axis_aresetn),
        .enable  (hs),
        .load    (lfsr_load),
        .seed    (C_LFSR_SEED),
        .state   (lfsr_state)
    );

    // Packet sequence number laid out big-endian: byte 0 carries the MSB
    assign seq_word = {pkts_q[7:0], pkts_q[15:8], pkts_q[23:16], pkts_q[31:24]};

    // Payload is a pure function of registered state, so it holds while stalled
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        byte_val     = '0;
        keep_bit     = 1'b0;
        if (state_q == StSend) begin
            for (int k = 0; k < int'(B); k++) begin
                keep_bit = !is_last || (rem_q == '0) || (k < int'(rem_q));
                unique case (mode_q)
                    C_PAT_BYTE_IDX: byte_val = 8'(k);
                    C_PAT_BEAT_IDX: byte_val = beat_q[7:0];
                    C_PAT_SEQ:      byte_val = (beat_q == '0 && k < 4) ?
                                               seq_word[8*(k%4) +: 8] : 8'(k);
                    C_PAT_LFSR:     byte_val = lfsr_state[8*(k%4) +: 8];
                    default:        byte_val = '0;
                endcase
                m_axis_tkeep[k] = keep_bit;
                if (keep_bit) begin
                    m_axis_tdata[8*k +: 8] = byte_val;
                end
            end
        end
    end

    assign m_axis_tlast = (state_q == StSend) && is_last;
    assign m_axis_tuser = 1'b0;
    assign busy         = (state_q != StIdle);
    assign cfg_error    = cfg_err_q;
    assign packets_sent = pkts_q;
    assign beats_sent   = beats_q;

endmodule
